hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised pipeline stall/flush controller for the in-order scalar core; successor to the fixed 5-stage stall unit.
- Produces a per-register hold/flush vector for N pipeline registers and a fetch gate.
- Resolves multi-cycle EX busy, load-use hazards and branches, with a selectable branch policy: stall-on-branch or predict-not-taken with flush.
- Keeps saturating performance counters. Sits beside the pipeline registers in the processor top.

Parameters:
NUM_STAGES, 5, pipeline stages; NUM_REGS = NUM_STAGES-1 registers, register k sits between stage k and stage k+1
EX_STG, 2, index of the execute stage (IF=0, ID=1); legal range 2..NUM_STAGES-2
REG_W, 5, register-address width
BR_MODE, 0, 0 = stall fetch from branch decode until resolve; 1 = predict-not-taken, flush on taken
CNT_W, 16, performance-counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
id_vld  in  1  valid instruction in ID
id_is_br  in  1  ID instruction is a branch or jump
id_rs1  in  REG_W  ID source 1
id_rs2  in  REG_W  ID source 2
id_rs_used  in  2  bit0 = rs1 read, bit1 = rs2 read
ex_vld  in  1  valid instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_rd  in  REG_W  EX destination
ex_busy  in  1  multi-cycle EX unit not finished
ex_br_done  in  1  branch resolved in EX this cycle
ex_take_br  in  1  resolved branch is taken (qualified by ex_br_done)
reg_en  out  NUM_REGS  per-register load enable
reg_flush  out  NUM_REGS  per-register bubble insert (clears valid); overrides reg_en
pc_en  out  1  PC may advance
br_stall  out  1  fetch inhibited due to pending branch
stall_cnt  out  CNT_W  cycles with any register held
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (rst=0, async): state RUN, both counters 0. Outputs during reset: reg_en all 1, reg_flush all 0, pc_en 1, br_stall 0.
- FSM states: RUN, BR_WAIT (BR_MODE 0 only), MC_WAIT.
- Load-use hazard (RUN, combinational):
  - Condition: ex_vld & ex_is_load & ex_rd!=0 & ((id_rs_used[0] & id_rs1==ex_rd) | (id_rs_used[1] & id_rs2==ex_rd)) & id_vld.
  - Response: reg_en[0..EX_STG-2]=0, pc_en=0, reg_flush[EX_STG-1]=1. One bubble, one cycle.
- EX busy (ex_busy=1, any state):
  - reg_en[0..EX_STG-1]=0, pc_en=0, reg_flush[EX_STG]=1; downstream registers keep flowing.
  - Enter MC_WAIT. Return to RUN on the first cycle ex_busy=0, in which all enables are 1.
- Branch, BR_MODE 0:
  - In RUN with id_vld & id_is_br and no higher-priority event: br_stall=1, pc_en=0, reg_flush[0]=1 in that same cycle; next state BR_WAIT.
  - BR_WAIT holds br_stall=1, pc_en=0, reg_flush[0]=1 until ex_br_done=1.
  - In the ex_br_done cycle: br_stall=0, pc_en=1; next state RUN.
  - If ex_busy rises in BR_WAIT, the busy response is applied on top while staying in BR_WAIT.
- Branch, BR_MODE 1:
  - br_stall is always 0.
  - On ex_br_done & ex_take_br: reg_flush[0..EX_STG-1]=1 in the same cycle, pc_en=1, flush_cnt+1.
  - Not taken: no action.
- Priority: reset > ex_busy > taken-branch flush (mode 1) > load-use > branch stall (mode 0).
  - A taken flush in the same cycle as a load-use hazard discards the load-use stall; the flushed ID instruction no longer exists.
- reg_flush[k]=1 forces reg_en[k]=1 so the bubble is written.
- Counters:
  - stall_cnt increments each cycle any reg_en bit is 0.
  - flush_cnt increments per taken flush, including a BR_MODE 0 resolve with ex_take_br=1.
  - Both saturate at all-ones; no wrap.
- id_rs*==0 never causes a hazard.
- Outputs are combinational from inputs and state. No extra latency.

Decomposition:
- Shared package: FSM state enum {RUN, BR_WAIT, MC_WAIT}, BR_MODE encodings, ZERO_REG constant.
- One sub-module, sat_counter (CNT_W, inc, value), instantiated twice for the performance counters.

Test Plan:
- Reset mid-BR_WAIT: assert rst=0 -> state RUN, br_stall=0, reg_en=4'b1111, reg_flush=0, counters 0 immediately, without waiting for a clock.
- Load-use, EX_STG=2: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs_used=01 -> one cycle reg_en=4'b1110, reg_flush=4'b0010, pc_en=0; stall_cnt=1.
- ex_busy held 3 cycles -> reg_en=4'b1100, reg_flush=4'b0100 for 3 cycles, then 4'b1111/0; stall_cnt=3.
- BR_MODE 0: id_is_br at cycle 0, ex_br_done=1 and ex_take_br=1 at cycle 2 -> br_stall=1 cycles 0-1, 0 at cycle 2; flush_cnt=1.
- BR_MODE 1: ex_take_br with a simultaneous load-use hazard -> reg_flush=4'b0011, pc_en=1, no stall; flush_cnt=1.
- CNT_W=4: hold ex_busy for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_e;

  localparam int BR_MODE_STALL = 0;
  localparam int BR_MODE_PNT   = 1;
  localparam int ZERO_REG      = 0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter used for hazard performance stats
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc_i && !(&value_q)) value_d = value_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush controller for an N-stage in-order pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int EX_STG     = 2,
  parameter int REG_W      = 5,
  parameter int BR_MODE    = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_vld_i,
  input  logic                  id_is_br_i,
  input  logic [REG_W-1:0]      id_rs1_i,
  input  logic [REG_W-1:0]      id_rs2_i,
  input  logic [1:0]            id_rs_used_i,
  input  logic                  ex_vld_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_W-1:0]      ex_rd_i,
  input  logic                  ex_busy_i,
  input  logic                  ex_br_done_i,
  input  logic                  ex_take_br_i,
  output logic [NUM_STAGES-2:0] reg_en_o,
  output logic [NUM_STAGES-2:0] reg_flush_o,
  output logic                  pc_en_o,
  output logic                  br_stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int NUM_REGS = NUM_STAGES - 1;

  state_e state_q, state_d;

  logic                load_use, taken_flush, br_start, br_hold;
  logic                stall_inc, flush_inc;
  logic [NUM_REGS-1:0] en_raw, flush;

  assign load_use = (state_q == ST_RUN) && id_vld_i && ex_vld_i && ex_is_load_i &&
                    (ex_rd_i != REG_W'(ZERO_REG)) &&
                    ((id_rs_used_i[0] && (id_rs1_i == ex_rd_i)) ||
                     (id_rs_used_i[1] && (id_rs2_i == ex_rd_i)));

  assign taken_flush = (BR_MODE == BR_MODE_PNT) && ex_br_done_i && ex_take_br_i && !ex_busy_i;

  // Branch stall only starts once nothing of higher priority claims the cycle.
  assign br_start = (BR_MODE == BR_MODE_STALL) && (state_q == ST_RUN) && id_vld_i &&
                    id_is_br_i && !ex_busy_i && !load_use;
  assign br_hold  = (state_q == ST_BR_WAIT) && !ex_br_done_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (ex_busy_i)     state_d = ST_MC_WAIT;
        else if (br_start) state_d = ST_BR_WAIT;
      end
      ST_BR_WAIT: begin
        if (ex_br_done_i) state_d = ex_busy_i ? ST_MC_WAIT : ST_RUN;
      end
      ST_MC_WAIT: begin
        if (!ex_busy_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    en_raw     = '1;
    flush      = '0;
    pc_en_o    = 1'b1;
    br_stall_o = 1'b0;
    if (rst_ni) begin
      if (ex_busy_i) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (k < EX_STG)  en_raw[k] = 1'b0;
          if (k == EX_STG) flush[k]  = 1'b1;
        end
        pc_en_o = 1'b0;
        if (br_hold) begin
          br_stall_o = 1'b1;
          flush[0]   = 1'b1;
        end
      end else if (taken_flush) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (k < EX_STG) flush[k] = 1'b1;
        end
      end else if (load_use) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (k < EX_STG - 1)  en_raw[k] = 1'b0;
          if (k == EX_STG - 1) flush[k]  = 1'b1;
        end
        pc_en_o = 1'b0;
      end else if (br_start || br_hold) begin
        br_stall_o = 1'b1;
        pc_en_o    = 1'b0;
        flush[0]   = 1'b1;
      end
    end
  end

  // A flushed register must still load so the bubble is actually written.
  assign reg_en_o    = en_raw | flush;
  assign reg_flush_o = flush;

  assign stall_inc = !(&reg_en_o);
  assign flush_inc = taken_flush ||
                     ((state_q == ST_BR_WAIT) && ex_br_done_i && ex_take_br_i);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (stall_inc),
    .value_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (flush_inc),
    .value_o (flush_cnt_o)
  );

endmodule
